// File: rtl/vsynth_pkg.sv
// Shared constants and types for the wavetable voice allocator.
package vsynth_pkg;

    localparam int NOTE_W_DEF   = 7;
    localparam int RANK_W_MAX   = 4;

    // Values for the STEAL_MODE parameter of midi_voice_alloc.
    localparam int STEAL_OLDEST = 1;
    localparam int STEAL_NONE   = 0;

    // Full state of one voice, at the default field widths.
    typedef struct packed {
        logic                  gate;
        logic                  held;
        logic [NOTE_W_DEF-1:0] note;
        logic [NOTE_W_DEF-1:0] vel;
        logic [RANK_W_MAX-1:0] rank;
    } voice_state_t;

endpackage

// File: rtl/midi_voice_alloc_voice_pick.sv
// Combinational target selection for a note-on: retrigger, oldest free voice, or steal.
module voice_pick #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int RANK_W     = 2
) (
    input  logic [NUM_VOICES-1:0]        gate,
    input  logic [NUM_VOICES*NOTE_W-1:0] note,
    input  logic [NUM_VOICES*RANK_W-1:0] rank,
    input  logic [NOTE_W-1:0]            note_num,
    input  logic                         steal_mode,
    output logic [RANK_W-1:0]            target,
    output logic                         valid,
    output logic                         retrig
);

    logic              hit;
    logic [RANK_W-1:0] hit_idx;
    logic              free_found;
    logic [RANK_W-1:0] free_idx;
    logic [RANK_W-1:0] free_rank;
    logic [RANK_W-1:0] old_idx;

    // Scan all voices once for a matching gated note, the oldest free voice and the oldest voice overall.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        free_rank  = '0;
        old_idx    = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!hit && gate[i] && note[i*NOTE_W +: NOTE_W] == note_num) begin
                hit     = 1'b1;
                hit_idx = RANK_W'(i);
            end
            if (!gate[i] && (!free_found || rank[i*RANK_W +: RANK_W] > free_rank)) begin
                free_found = 1'b1;
                free_idx   = RANK_W'(i);
                free_rank  = rank[i*RANK_W +: RANK_W];
            end
            if (rank[i*RANK_W +: RANK_W] == RANK_W'(NUM_VOICES - 1)) begin
                old_idx = RANK_W'(i);
            end
        end
    end

    // Priority: retrigger, then free voice, then steal when enabled.
    always_comb begin
        target = '0;
        valid  = 1'b0;
        retrig = 1'b0;
        if (hit) begin
            target = hit_idx;
            valid  = 1'b1;
            retrig = 1'b1;
        end else if (free_found) begin
            target = free_idx;
            valid  = 1'b1;
        end else if (steal_mode) begin
            target = old_idx;
            valid  = 1'b1;
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps note events onto NUM_VOICES voices with LRU stealing.
module midi_voice_alloc
    import vsynth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = NOTE_W_DEF,
    parameter int STEAL_MODE = STEAL_OLDEST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         note_on,
    input  logic                         note_off,
    input  logic [NOTE_W-1:0]            note_num,
    input  logic [NOTE_W-1:0]            note_vel,
    input  logic                         sustain,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         drop,
    output logic [4:0]                   active_cnt
);

    localparam int RANK_W = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] held_q, held_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [NOTE_W-1:0]     vel_q  [NUM_VOICES];
    logic [NOTE_W-1:0]     vel_d  [NUM_VOICES];
    logic [RANK_W-1:0]     rank_q [NUM_VOICES];
    logic [RANK_W-1:0]     rank_d [NUM_VOICES];
    logic                  sus_q;
    logic                  drop_q, drop_d;
    logic [4:0]            cnt_q, cnt_d;

    logic [NUM_VOICES*NOTE_W-1:0] note_flat;
    logic [NUM_VOICES*NOTE_W-1:0] vel_flat;
    logic [NUM_VOICES*RANK_W-1:0] rank_flat;

    logic              do_off;
    logic              do_on;
    logic              sus_fall;
    logic [RANK_W-1:0] pick_target;
    logic              pick_valid;
    logic              pick_retrig;

    // Flatten per-voice registers for the picker and the output buses.
    always_comb begin
        note_flat = '0;
        vel_flat  = '0;
        rank_flat = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            note_flat[i*NOTE_W +: NOTE_W] = note_q[i];
            vel_flat[i*NOTE_W +: NOTE_W]  = vel_q[i];
            rank_flat[i*RANK_W +: RANK_W] = rank_q[i];
        end
    end

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .RANK_W     (RANK_W)
    ) u_pick (
        .gate       (gate_q),
        .note       (note_flat),
        .rank       (rank_flat),
        .note_num   (note_num),
        .steal_mode (STEAL_MODE == STEAL_OLDEST),
        .target     (pick_target),
        .valid      (pick_valid),
        .retrig     (pick_retrig)
    );

    // Event decode: all_off beats note_off beats note_on; zero velocity note_on acts as note_off.
    always_comb begin
        do_off   = !all_off && (note_off || (note_on && note_vel == '0));
        do_on    = !all_off && !note_off && note_on && note_vel != '0;
        sus_fall = sus_q && !sustain;
    end

    // Next-state voice table: sustain release first, then the single chosen event.
    always_comb begin
        gate_d = gate_q;
        held_d = held_q;
        trig_d = '0;
        drop_d = 1'b0;
        note_d = note_q;
        vel_d  = vel_q;
        rank_d = rank_q;
        if (sus_fall) begin
            gate_d = gate_q & ~held_q;
            held_d = '0;
        end
        if (all_off) begin
            gate_d = '0;
            held_d = '0;
        end else if (do_off) begin
            // Matching uses registered gates, so a voice released by the pedal this cycle still matches.
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (gate_q[i] && note_q[i] == note_num) begin
                    if (sustain) begin
                        held_d[i] = 1'b1;
                    end else begin
                        gate_d[i] = 1'b0;
                    end
                end
            end
        end else if (do_on) begin
            if (pick_valid) begin
                gate_d[pick_target] = 1'b1;
                held_d[pick_target] = 1'b0;
                trig_d[pick_target] = 1'b1;
                vel_d[pick_target]  = note_vel;
                if (!pick_retrig) begin
                    note_d[pick_target] = note_num;
                end
                for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                    if (rank_q[i] < rank_q[pick_target]) begin
                        rank_d[i] = rank_q[i] + RANK_W'(1);
                    end
                end
                rank_d[pick_target] = '0;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Popcount of the next-state gates for the display.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            cnt_d = cnt_d + 5'(gate_d[i]);
        end
    end

    // State and output registers; reset restores ranks to the voice index.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q <= '0;
            held_q <= '0;
            trig_q <= '0;
            drop_q <= 1'b0;
            cnt_q  <= '0;
            sus_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= RANK_W'(i);
            end
        end else begin
            gate_q <= gate_d;
            held_q <= held_d;
            trig_q <= trig_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            sus_q  <= sustain;
            note_q <= note_d;
            vel_q  <= vel_d;
            rank_q <= rank_d;
        end
    end

    assign voice_gate = gate_q;
    assign voice_note = note_flat;
    assign voice_vel  = vel_flat;
    assign voice_trig = trig_q;
    assign drop       = drop_q;
    assign active_cnt = cnt_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench: three allocator configurations driven by one stimulus stream.
module tb_midi_voice_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       note_on = 1'b0;
    logic       note_off = 1'b0;
    logic [6:0] note_num = '0;
    logic [6:0] note_vel = '0;
    logic       sustain = 1'b0;
    logic       all_off = 1'b0;

    logic [3:0]  a_gate, a_trig, b_gate, b_trig;
    logic [27:0] a_note, a_vel, b_note, b_vel;
    logic        a_drop, b_drop, c_drop;
    logic [4:0]  a_cnt, b_cnt, c_cnt;
    logic [7:0]  c_gate, c_trig;
    logic [55:0] c_note, c_vel;

    int checks = 0;
    int errors = 0;
    bit cur_sus = 1'b0;

    typedef struct {
        bit [15:0]  gate;
        bit [127:0] note;
        bit [127:0] vel;
        bit [15:0]  trig;
        bit         drop;
        bit [4:0]   cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    bit [15:0] m_gate [3];
    bit [15:0] m_held [3];
    bit [6:0]  m_note [3][16];
    bit [6:0]  m_vel  [3][16];
    int        m_rank [3][16];
    bit        m_sus  [3];

    always #5 clk = ~clk;

    midi_voice_alloc #(.NUM_VOICES(4), .NOTE_W(7), .STEAL_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
        .note_num(note_num), .note_vel(note_vel), .sustain(sustain), .all_off(all_off),
        .voice_gate(a_gate), .voice_note(a_note), .voice_vel(a_vel),
        .voice_trig(a_trig), .drop(a_drop), .active_cnt(a_cnt)
    );

    midi_voice_alloc #(.NUM_VOICES(4), .NOTE_W(7), .STEAL_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
        .note_num(note_num), .note_vel(note_vel), .sustain(sustain), .all_off(all_off),
        .voice_gate(b_gate), .voice_note(b_note), .voice_vel(b_vel),
        .voice_trig(b_trig), .drop(b_drop), .active_cnt(b_cnt)
    );

    midi_voice_alloc #(.NUM_VOICES(8), .NOTE_W(7), .STEAL_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
        .note_num(note_num), .note_vel(note_vel), .sustain(sustain), .all_off(all_off),
        .voice_gate(c_gate), .voice_note(c_note), .voice_vel(c_vel),
        .voice_trig(c_trig), .drop(c_drop), .active_cnt(c_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one allocator; selection uses the gates from before this cycle.
    function automatic exp_t model_step(input int c, input int n, input bit steal, input bit r,
                                        input bit on, input bit off, input bit [6:0] num,
                                        input bit [6:0] vel, input bit sus, input bit alloff);
        exp_t      e;
        bit [15:0] g0;
        bit        fall;
        int        v;
        int        best;
        int        rv;
        e.gate = '0; e.note = '0; e.vel = '0; e.trig = '0; e.drop = 1'b0; e.cnt = '0;
        fall = m_sus[c] && !sus;
        g0   = m_gate[c];
        if (r) begin
            m_gate[c] = '0;
            m_held[c] = '0;
            m_sus[c]  = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_note[c][i] = '0;
                m_vel[c][i]  = '0;
                m_rank[c][i] = i;
            end
        end else begin
            m_sus[c] = sus;
            if (fall) begin
                for (int i = 0; i < n; i++) begin
                    if (m_held[c][i]) begin
                        m_gate[c][i] = 1'b0;
                        m_held[c][i] = 1'b0;
                    end
                end
            end
            if (alloff) begin
                m_gate[c] = '0;
                m_held[c] = '0;
            end else if (off || (on && vel == 0)) begin
                for (int i = 0; i < n; i++) begin
                    if (g0[i] && m_note[c][i] == num) begin
                        if (sus) m_held[c][i] = 1'b1;
                        else     m_gate[c][i] = 1'b0;
                    end
                end
            end else if (on) begin
                v = -1;
                for (int i = 0; i < n; i++)
                    if (v < 0 && g0[i] && m_note[c][i] == num) v = i;
                if (v < 0) begin
                    best = -1;
                    for (int i = 0; i < n; i++)
                        if (!g0[i] && m_rank[c][i] > best) begin
                            best = m_rank[c][i];
                            v = i;
                        end
                end
                if (v < 0 && steal)
                    for (int i = 0; i < n; i++)
                        if (m_rank[c][i] == n - 1) v = i;
                if (v < 0) begin
                    e.drop = 1'b1;
                end else begin
                    m_gate[c][v] = 1'b1;
                    m_held[c][v] = 1'b0;
                    m_note[c][v] = num;
                    m_vel[c][v]  = vel;
                    e.trig[v]    = 1'b1;
                    rv = m_rank[c][v];
                    for (int j = 0; j < n; j++)
                        if (m_rank[c][j] < rv) m_rank[c][j]++;
                    m_rank[c][v] = 0;
                end
            end
        end
        e.gate = m_gate[c];
        for (int i = 0; i < n; i++) begin
            e.note[i*7 +: 7] = m_note[c][i];
            e.vel[i*7 +: 7]  = m_vel[c][i];
            if (m_gate[c][i]) e.cnt++;
        end
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
            check_eq("scoreboard_empty", 1, 0);
            return;
        end
        e = q0.pop_front();
        check_eq("a_gate", a_gate, e.gate);
        check_eq("a_note", a_note, e.note);
        check_eq("a_vel",  a_vel,  e.vel);
        check_eq("a_trig", a_trig, e.trig);
        check_eq("a_drop", a_drop, e.drop);
        check_eq("a_cnt",  a_cnt,  e.cnt);
        e = q1.pop_front();
        check_eq("b_gate", b_gate, e.gate);
        check_eq("b_note", b_note, e.note);
        check_eq("b_vel",  b_vel,  e.vel);
        check_eq("b_trig", b_trig, e.trig);
        check_eq("b_drop", b_drop, e.drop);
        check_eq("b_cnt",  b_cnt,  e.cnt);
        e = q2.pop_front();
        check_eq("c_gate", c_gate, e.gate);
        check_eq("c_note", c_note, e.note);
        check_eq("c_vel",  c_vel,  e.vel);
        check_eq("c_trig", c_trig, e.trig);
        check_eq("c_drop", c_drop, e.drop);
        check_eq("c_cnt",  c_cnt,  e.cnt);
    endtask

    // One clock of stimulus: push expectations, clock, then compare after the edge.
    task automatic drive(input bit r, input bit on, input bit off, input bit [6:0] num,
                         input bit [6:0] vel, input bit sus, input bit alloff);
        rst      = r;
        note_on  = on;
        note_off = off;
        note_num = num;
        note_vel = vel;
        sustain  = sus;
        all_off  = alloff;
        q0.push_back(model_step(0, 4, 1'b1, r, on, off, num, vel, sus, alloff));
        q1.push_back(model_step(1, 4, 1'b0, r, on, off, num, vel, sus, alloff));
        q2.push_back(model_step(2, 8, 1'b1, r, on, off, num, vel, sus, alloff));
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, cur_sus, 1'b0);
    endtask

    task automatic on_ev(input bit [6:0] num, input bit [6:0] vel);
        drive(1'b0, 1'b1, 1'b0, num, vel, cur_sus, 1'b0);
    endtask

    task automatic off_ev(input bit [6:0] num);
        drive(1'b0, 1'b0, 1'b1, num, 7'd0, cur_sus, 1'b0);
    endtask

    task automatic reset_ev();
        drive(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, cur_sus, 1'b0);
    endtask

    initial begin
        bit r, on, off, ao;
        reset_ev();
        reset_ev();
        check_eq("rst_a_gate", a_gate, 0);
        check_eq("rst_c_cnt", c_cnt, 0);

        // First note lands on the highest-ranked free voice.
        on_ev(7'd60, 7'd100);
        check_eq("first_gate", a_gate, 4'b1000);
        check_eq("first_note", a_note[27:21], 60);
        check_eq("first_vel", a_vel[27:21], 100);
        check_eq("first_trig", a_trig, 4'b1000);
        check_eq("first_cnt", a_cnt, 1);
        check_eq("first_trig_c", c_trig, 8'h80);

        on_ev(7'd62, 7'd90);
        on_ev(7'd64, 7'd80);
        on_ev(7'd65, 7'd70);
        on_ev(7'd67, 7'd60);
        check_eq("steal_trig", a_trig, 4'b1000);
        check_eq("steal_note", a_note[27:21], 67);
        check_eq("steal_cnt", a_cnt, 4);
        check_eq("drop_pulse", b_drop, 1);
        check_eq("drop_gate", b_gate, 4'hF);
        check_eq("drop_trig", b_trig, 0);
        check_eq("drop_note", b_note[27:21], 60);
        idle();
        check_eq("drop_clear", b_drop, 0);

        // all_off beats a simultaneous note_on.
        drive(1'b0, 1'b1, 1'b0, 7'd70, 7'd10, cur_sus, 1'b1);
        check_eq("alloff_a", a_gate, 0);
        check_eq("alloff_c", c_gate, 0);
        check_eq("alloff_trig", a_trig, 0);

        on_ev(7'd60, 7'd50);
        on_ev(7'd60, 7'd90);
        check_eq("retrig_cnt", a_cnt, 1);
        check_eq("retrig_ntrig", $countones(a_trig), 1);

        drive(1'b0, 1'b0, 1'b0, 7'd0, 7'd0, cur_sus, 1'b1);
        cur_sus = 1'b1;
        idle();
        on_ev(7'd62, 7'd40);
        off_ev(7'd62);
        check_eq("sus_hold_cnt", a_cnt, 1);
        cur_sus = 1'b0;
        idle();
        check_eq("sus_release_cnt", a_cnt, 0);

        on_ev(7'd64, 7'd80);
        check_eq("vel0_pre_cnt", a_cnt, 1);
        on_ev(7'd64, 7'd0);
        check_eq("vel0_off_cnt", a_cnt, 0);

        // Eight voices: release the third note only, then reset restores ranks.
        reset_ev();
        for (int i = 0; i < 8; i++) on_ev(7'(50 + i), 7'(20 + i));
        check_eq("c_full_cnt", c_cnt, 8);
        off_ev(7'd52);
        check_eq("c_off3_gate", c_gate, 8'hDF);
        check_eq("c_off3_cnt", c_cnt, 7);
        reset_ev();
        check_eq("c_rst_gate", c_gate, 0);
        check_eq("c_rst_note", c_note, 0);
        on_ev(7'd40, 7'd30);
        check_eq("c_rank_restore", c_trig, 8'h80);

        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(0, 99) == 0);
            ao  = ($urandom_range(0, 39) == 0);
            on  = ($urandom_range(0, 2) != 0);
            off = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) cur_sus = ~cur_sus;
            drive(r, on, off, 7'(60 + $urandom_range(0, 9)),
                  ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                  cur_sus, ao);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_voice_alloc.md
# midi_voice_alloc

Polyphonic voice allocator between the MIDI parser and a bank of `NUM_VOICES` wavetable voices. It consumes single-cycle note-on, note-off, sustain and all-off events and assigns each note to a voice. When all voices are busy it either steals the least-recently-assigned voice or drops the note, according to `STEAL_MODE`. It drives per-voice gate, note, velocity and a retrigger pulse into the synthesis bank, plus an active-voice count for the 7-segment display.

## Interface
- `NUM_VOICES`, 4, number of voices; legal range 2..16.
- `NOTE_W`, 7, width of the note and velocity fields.
- `STEAL_MODE`, 1, 1 = steal oldest voice when full; 0 = drop the note and pulse `drop`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `note_on`  in  1  single-cycle note-on strobe.
- `note_off`  in  1  single-cycle note-off strobe.
- `note_num`  in  `NOTE_W`  note number; valid with either strobe.
- `note_vel`  in  `NOTE_W`  velocity; valid with `note_on`.
- `sustain`  in  1  sustain pedal level (CC64 ≥ 64, decoded upstream).
- `all_off`  in  1  single-cycle strobe that silences every voice.
- `voice_gate`  out  `NUM_VOICES`  per-voice gate.
- `voice_note`  out  `NUM_VOICES*NOTE_W`  voice i occupies bits [i*NOTE_W +: NOTE_W].
- `voice_vel`  out  `NUM_VOICES*NOTE_W`  same packing as `voice_note`.
- `voice_trig`  out  `NUM_VOICES`  one-cycle pulse when a voice is (re)assigned; used for phase/envelope reset.
- `drop`  out  1  one-cycle pulse when a note-on is discarded.
- `active_cnt`  out  5  number of voices with gate high.

## Operation
- **Per-voice state:** `gate`, `held` (released under sustain), `note`, `vel`, `rank` (clog2 of `NUM_VOICES` bits).
  - Ranks form a permutation of 0..N-1.
  - rank 0 = newest assignment; rank N-1 = oldest.
- **Reset:** all `gate`/`held` = 0, `note`/`vel` = 0, rank[i] = i. All outputs are 0.
- **Event priority per cycle:** `all_off` > `note_off` > `note_on`.
  - Only the highest-priority strobe present is processed; lower ones in the same cycle are ignored.
  - A `note_on` with `note_vel` == 0 is processed as a `note_off`.
- **note_on, target selection (first match wins):**
  1. A voice with gate=1 and `note` == `note_num` → retrigger it.
  2. Otherwise, the free voice (gate=0) with the highest rank.
  3. Otherwise, if `STEAL_MODE`=1, the voice with rank N-1.
  4. Otherwise drop: no state change, `drop` pulses.
- **On assigning voice v:**
  - gate=1, held=0, `note`/`vel` loaded, `voice_trig[v]` pulses.
  - Rank update: every voice with rank < rank[v] increments; rank[v] becomes 0.
- **note_off:** every voice with gate=1 and a matching note:
  - if `sustain`=0 → gate cleared;
  - if `sustain`=1 → held set, gate stays high.
  - No match → no effect.
- **sustain falling edge** (registered previous value): every held voice clears gate and held.
  - This is evaluated in addition to any event processed in the same cycle.
  - A note_off in the falling-edge cycle sees `sustain`=0 and clears gate directly.
- **all_off:** all gate and held cleared. Ranks and note/vel are unchanged.
- **Stealing:** a held voice can be stolen; held clears on reassignment.
- **Registered state:** `note`/`vel` of a gated-off voice keep their last values (release tail).
- **`active_cnt`:** registered popcount of the next-state gates.

## Timing
- Event in cycle t → `voice_gate`/`note`/`vel`/`active_cnt` updated at t+1.
- `voice_trig` and `drop` are high only during t+1.
- Back-to-back events on consecutive cycles are fully supported. There is no backpressure and no busy state.
- `rst` has priority over any event in the same cycle. Reset mid-sustain discards held voices.
- All outputs come straight from flops; there is no combinational input→output path.

## Structure
- Package `vsynth_pkg`:
  - `NOTE_W` default;
  - `STEAL_OLDEST`/`STEAL_NONE` constants;
  - voice-state struct typedef (gate, held, note, vel, rank).
- Sub-module `voice_pick` (combinational): inputs are the gate/note/rank vectors, `note_num` and `STEAL_MODE`; outputs are target index, valid and retrigger flag.
- Everything else (state registers, rank update, sustain edge, popcount) lives in `midi_voice_alloc`.

## Test plan
- Reset, then note_on 60/100 → t+1: voice 3 gate=1 (highest rank free), note 60, vel 100, `trig`=0b1000, `active_cnt`=1.
- Four note_ons 60, 62, 64, 65, then note_on 67 with `STEAL_MODE`=1 → the voice holding 60 is reassigned to 67 with trig pulse, `active_cnt`=4. With `STEAL_MODE`=0 → `drop` pulses and state is unchanged.
- note_on 60 twice (vel 50, then 90) → same voice, vel 90, two trig pulses, `active_cnt`=1.
- sustain=1, note_on 62, note_off 62 → gate stays 1. sustain→0 → gate clears the following cycle.
- note_on 64 with vel 0 → behaves as note_off 64. `all_off` together with note_on in the same cycle → all gates 0 and note_on ignored.
- `NUM_VOICES`=8: 8 note_ons, then note_off for the 3rd note → only that voice's gate drops and `active_cnt`=7. Assert `rst` mid-stream → all outputs 0 next cycle and ranks are restored (the next note_on lands on voice 7).
